// File: rtl/rst_seq_ctrl_pkg.sv
// Shared types and defaults for the reset sequencer slice.
// Latency: n/a (types, constants and elaboration-time helpers only).
// Backpressure: n/a.
package rst_seq_ctrl_pkg;

  localparam int DEF_N_DOM    = 4;
  localparam int DEF_DLY_W    = 8;
  localparam int DEF_HOLD_CYC = 8;

  // Encodings are visible on the optional debug port, so keep them fixed.
  typedef enum logic [2:0] {
    ST_RST     = 3'd0,
    ST_RELEASE = 3'd1,
    ST_RUN     = 3'd2,
    ST_SW_HOLD = 3'd3,
    ST_SW_ACK  = 3'd4
  } seq_state_t;

  // Domain index width; a single domain still needs a one-bit index.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Hold counter is loaded with HOLD_CYC-1, so clog2(HOLD_CYC) bits suffice.
  function automatic int hold_width(input int h);
    return (h > 1) ? $clog2(h) : 1;
  endfunction

endpackage

// File: rtl/rst_dly_cnt.sv
// Loadable saturating down-counter with a zero flag.
// Latency: value updates on the clock edge after load/dec; zero is combinational on the count.
// Backpressure: none; load wins over decrement, decrement stops at zero.
module rst_dly_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt_q;

  // Count register: load has priority, decrement never wraps below zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/rst_seq_ctrl.sv
// Sequenced per-domain reset release with a software reset hold/ack handshake.
// Latency: domain i releases dly_i+1 cycles after the previous one; sw reset asserts on the sampling edge.
// Backpressure: sw_rst_ack is held until sw_rst_req falls; RST_SEQ_STATUS_EN adds dbg_state/dbg_idx.
module rst_seq_ctrl
  import rst_seq_ctrl_pkg::*;
#(
  parameter int N_DOM    = DEF_N_DOM,
  parameter int DLY_W    = DEF_DLY_W,
  parameter int HOLD_CYC = DEF_HOLD_CYC
) (
  input  logic                   clk,
  input  logic                   rstn_async,
  input  logic [N_DOM*DLY_W-1:0] dly_cfg,
  input  logic                   sw_rst_req,
  output logic [N_DOM-1:0]       rstn_dom,
  output logic                   seq_done,
  output logic                   sw_rst_ack
`ifdef RST_SEQ_STATUS_EN
  ,
  output logic [2:0]                  dbg_state,
  output logic [idx_width(N_DOM)-1:0] dbg_idx
`endif
);

  localparam int IDX_W  = idx_width(N_DOM);
  localparam int HOLD_W = hold_width(HOLD_CYC);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYC - 1);

  logic [1:0]       sync_q;
  logic             rst_sync_n;

  seq_state_t       state_q;
  seq_state_t       state_d;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] idx_d;
  logic [N_DOM-1:0] rel_q;
  logic [N_DOM-1:0] rel_d;
  logic             done_q;
  logic             done_d;
  logic             ack_q;
  logic             ack_d;

  logic             rel_load;
  logic             rel_dec;
  logic             rel_zero;
  logic [DLY_W-1:0] rel_load_val;
  logic             hold_load;
  logic             hold_dec;
  logic             hold_zero;

  logic             last_dom;
  logic [DLY_W-1:0] dly_first;
  logic [DLY_W-1:0] dly_next;

  // Reset synchronizer: asserts immediately, releases two edges after rstn_async rises.
  always_ff @(posedge clk or negedge rstn_async) begin
    if (!rstn_async) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], 1'b1};
    end
  end

  assign rst_sync_n = sync_q[1];

  assign dly_first = dly_cfg[DLY_W-1:0];
  assign last_dom  = (idx_q == IDX_W'(N_DOM - 1));

  // Delay for the domain after the current one; sampled only on its load edge.
  always_comb begin
    dly_next = '0;
    for (int i = 1; i < N_DOM; i++) begin
      if (idx_q == IDX_W'(i - 1)) begin
        dly_next = dly_cfg[i*DLY_W +: DLY_W];
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      state_q <= ST_RST;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a software request beats a pending domain release.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RST:     state_d = ST_RELEASE;
      ST_RELEASE: begin
        if (sw_rst_req) begin
          state_d = ST_SW_HOLD;
        end else if (rel_zero && last_dom) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN:     if (sw_rst_req) state_d = ST_SW_HOLD;
      ST_SW_HOLD: if (hold_zero) state_d = ST_SW_ACK;
      ST_SW_ACK:  if (!sw_rst_req) state_d = ST_RELEASE;
      default:    state_d = ST_RST;
    endcase
  end

  // Output and datapath control: next release mask, index and counter commands.
  always_comb begin
    idx_d        = idx_q;
    rel_d        = rel_q;
    rel_load     = 1'b0;
    rel_load_val = dly_first;
    rel_dec      = 1'b0;
    hold_load    = 1'b0;
    hold_dec     = 1'b0;
    case (state_q)
      ST_RST: begin
        rel_load = 1'b1;
        idx_d    = '0;
      end
      ST_RELEASE, ST_RUN: begin
        if (sw_rst_req) begin
          rel_d     = '0;
          idx_d     = '0;
          hold_load = 1'b1;
        end else if (state_q == ST_RELEASE) begin
          if (rel_zero) begin
            for (int i = 0; i < N_DOM; i++) begin
              if (idx_q == IDX_W'(i)) rel_d[i] = 1'b1;
            end
            // The last domain keeps its index; there is nothing further to load.
            if (!last_dom) begin
              idx_d        = idx_q + IDX_W'(1);
              rel_load     = 1'b1;
              rel_load_val = dly_next;
            end
          end else begin
            rel_dec = 1'b1;
          end
        end
      end
      ST_SW_HOLD: hold_dec = 1'b1;
      ST_SW_ACK: begin
        // Leaving the ack restarts the sequence exactly as a fresh E0.
        if (!sw_rst_req) begin
          rel_load = 1'b1;
          idx_d    = '0;
        end
      end
      default: ;
    endcase
    done_d = (state_d == ST_RUN);
    ack_d  = (state_d == ST_SW_ACK);
  end

  // Registered outputs so nothing glitches high when the reset lifts.
  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      idx_q  <= '0;
      rel_q  <= '0;
      done_q <= 1'b0;
      ack_q  <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      rel_q  <= rel_d;
      done_q <= done_d;
      ack_q  <= ack_d;
    end
  end

  assign rstn_dom   = rel_q;
  assign seq_done   = done_q;
  assign sw_rst_ack = ack_q;

  rst_dly_cnt #(.W(DLY_W)) u_rel_cnt (
    .clk      (clk),
    .rst_n    (rst_sync_n),
    .load     (rel_load),
    .load_val (rel_load_val),
    .dec      (rel_dec),
    .zero     (rel_zero)
  );

  rst_dly_cnt #(.W(HOLD_W)) u_hold_cnt (
    .clk      (clk),
    .rst_n    (rst_sync_n),
    .load     (hold_load),
    .load_val (HOLD_LOAD),
    .dec      (hold_dec),
    .zero     (hold_zero)
  );

`ifdef RST_SEQ_STATUS_EN
  // Debug mirror of state and index, registered alongside the outputs.
  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      dbg_state <= '0;
      dbg_idx   <= '0;
    end else begin
      dbg_state <= state_d;
      dbg_idx   <= idx_d;
    end
  end
`endif

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Randomized self-checking bench for rst_seq_ctrl against a release-schedule model.
// Latency: expected release edges come from cumulative (dly_i + 1) sums after E0.
// Backpressure: sw request lengths are randomized around the hold/ack window.
module tb_rst_seq_ctrl;

  localparam int N_DOM    = 4;
  localparam int DLY_W    = 8;
  localparam int HOLD_CYC = 8;

  logic                   clk = 1'b0;
  logic                   rstn_async;
  logic [N_DOM*DLY_W-1:0] dly_cfg;
  logic                   sw_rst_req;
  logic [N_DOM-1:0]       rstn_dom;
  logic                   seq_done;
  logic                   sw_rst_ack;

  int n_checks = 0;
  int n_errors = 0;
  int cfg [N_DOM];

  rst_seq_ctrl #(
    .N_DOM    (N_DOM),
    .DLY_W    (DLY_W),
    .HOLD_CYC (HOLD_CYC)
  ) u_dut (
    .clk        (clk),
    .rstn_async (rstn_async),
    .dly_cfg    (dly_cfg),
    .sw_rst_req (sw_rst_req),
    .rstn_dom   (rstn_dom),
    .seq_done   (seq_done),
    .sw_rst_ack (sw_rst_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_outs(input string tag, input logic [N_DOM-1:0] dom, input logic done,
                          input logic ack);
    chk({tag, "_dom"}, 32'(rstn_dom), 32'(dom));
    chk({tag, "_done"}, 32'(seq_done), 32'(done));
    chk({tag, "_ack"}, 32'(sw_rst_ack), 32'(ack));
  endtask

  // Advance one rising edge and settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input int c0, input int c1, input int c2, input int c3);
    cfg[0] = c0; cfg[1] = c1; cfg[2] = c2; cfg[3] = c3;
    for (int i = 0; i < N_DOM; i++) dly_cfg[i*DLY_W +: DLY_W] = DLY_W'(cfg[i]);
  endtask

  task automatic set_cfg_rand(input int maxd);
    for (int i = 0; i < N_DOM; i++) cfg[i] = int'($urandom_range(0, maxd));
    for (int i = 0; i < N_DOM; i++) dly_cfg[i*DLY_W +: DLY_W] = DLY_W'(cfg[i]);
  endtask

  // Called just after E0. mode 1 scribbles over delays already consumed,
  // mode 2 moves domain 2's delay to 7 right after its load edge.
  task automatic run_release(input int stop_k, input int mode);
    int rel [N_DOM];
    int acc;
    int last_k;
    logic [N_DOM-1:0] m;
    acc = 0;
    for (int i = 0; i < N_DOM; i++) begin
      acc += cfg[i] + 1;
      rel[i] = acc;
    end
    last_k = (stop_k < 0) ? rel[N_DOM-1] + 3 : stop_k;
    for (int k = 1; k <= last_k; k++) begin
      step();
      for (int i = 0; i < N_DOM; i++) m[i] = (k >= rel[i]);
      chk_outs("rel", m, k >= rel[N_DOM-1], 1'b0);
      if (mode == 1) begin
        if ($urandom_range(0, 1) == 1) dly_cfg[DLY_W-1:0] = DLY_W'($urandom_range(0, 255));
        for (int i = 1; i < N_DOM; i++)
          if (k >= rel[i-1] && $urandom_range(0, 1) == 1)
            dly_cfg[i*DLY_W +: DLY_W] = DLY_W'($urandom_range(0, 255));
      end else if (mode == 2 && k == rel[1]) begin
        dly_cfg[2*DLY_W +: DLY_W] = DLY_W'(7);
      end
    end
  endtask

  // Drops rstn_async for 3 ns between edges; outputs must clear without a clock.
  task automatic pulse_reset();
    #2;
    rstn_async = 1'b0;
    #1;
    chk_outs("async_rst", '0, 1'b0, 1'b0);
    #2;
    rstn_async = 1'b1;
  endtask

  // Two synchronizer edges, then E0; everything stays low throughout.
  task automatic restart_to_e0();
    for (int e = 0; e < 3; e++) begin
      step();
      chk_outs("resync", '0, 1'b0, 1'b0);
    end
  endtask

  // sw_rst_req is already high; next edge is H0. req falls after edge r.
  // Ends right after the edge that restarts the sequence (new E0).
  task automatic sw_phase(input int r, input int abort_k);
    int drop;
    drop = ((r > HOLD_CYC) ? r : HOLD_CYC) + 1;
    step();
    chk_outs("sw_h0", '0, 1'b0, 1'b0);
    if (r == 0) sw_rst_req = 1'b0;
    for (int k = 1; k <= drop; k++) begin
      step();
      chk_outs("sw_hold", '0, 1'b0, (k >= HOLD_CYC) && (k < drop));
      if (k == abort_k) begin
        pulse_reset();
        return;
      end
      if (k == r) sw_rst_req = 1'b0;
    end
  endtask

  initial begin
    int total;
    rstn_async = 1'b0;
    sw_rst_req = 1'b0;
    set_cfg(2, 5, 0, 3);
    repeat (3) step();
    chk_outs("reset", '0, 1'b0, 1'b0);

    // Power-on release with the reference delays.
    rstn_async = 1'b1;
    restart_to_e0();
    run_release(-1, 0);

    // Two-cycle software request from RUN, same delays afterwards.
    sw_rst_req = 1'b1;
    sw_phase(1, -1);
    run_release(-1, 0);

    // All-zero delays: back-to-back releases.
    set_cfg(0, 0, 0, 0);
    sw_rst_req = 1'b1;
    sw_phase(0, -1);
    run_release(-1, 0);

    // Request held 20 cycles past the ack; then domain 2 delay edited after load.
    set_cfg(1, 2, 0, 4);
    sw_rst_req = 1'b1;
    sw_phase(HOLD_CYC + 20, -1);
    run_release(-1, 2);

    // Async reset pulse just after domain 1 releases.
    set_cfg(2, 5, 0, 3);
    sw_rst_req = 1'b1;
    sw_phase(0, -1);
    run_release(9, 0);
    pulse_reset();
    set_cfg_rand(6);
    restart_to_e0();
    run_release(-1, 1);

    // Request high across reset release: ignored at E0, honoured one edge later.
    sw_rst_req = 1'b1;
    pulse_reset();
    set_cfg_rand(6);
    restart_to_e0();
    sw_phase(3, -1);
    run_release(-1, 1);

    // Async reset while the ack is up.
    sw_rst_req = 1'b1;
    sw_phase(HOLD_CYC + 5, HOLD_CYC + 2);
    sw_rst_req = 1'b0;
    set_cfg_rand(6);
    restart_to_e0();
    run_release(-1, 1);

    // Random software resets landing in RELEASE or RUN.
    for (int it = 0; it < 8; it++) begin
      set_cfg_rand(6);
      sw_rst_req = 1'b1;
      sw_phase(int'($urandom_range(0, HOLD_CYC + 4)), -1);
      total = cfg[0] + cfg[1] + cfg[2] + cfg[3] + N_DOM;
      run_release(int'($urandom_range(1, total + 3)), 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
